// File: rtl/kp_out_serializer_pkg.sv
// Shared ECC constants and the output serializer state type.
// Used by the operand loader and by kp_out_serializer so both sides
// agree on coordinate width and nibble framing.
package ecc_pkg;

  localparam int SIZE             = 32;
  localparam int NIBBLE_W         = 4;
  localparam int NIBBLES_PER_WORD = SIZE / NIBBLE_W;
  localparam int FRAME_W          = 2 * SIZE;
  localparam int CNT_W            = 4;

  // Counter values at which the final x nibble and final y nibble transfer.
  localparam logic [CNT_W-1:0] X_LAST_CNT = CNT_W'(NIBBLES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] Y_LAST_CNT = CNT_W'(2 * NIBBLES_PER_WORD - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_X,
    ST_SEND_Y,
    ST_CKSUM,
    ST_DONE
  } ser_state_t;

endpackage

// File: rtl/kp_out_serializer_if.sv
// Nibble stream bus carrying the kP result out of the ECC top.
// The master drives valid/nibble/last; the slave answers with ready.
interface kp_out_serializer_if;
  import ecc_pkg::*;

  logic                valid;
  logic [NIBBLE_W-1:0] nibble;
  logic                last;
  logic                ready;

  modport master (output valid, output nibble, output last, input ready);
  modport slave  (input valid, input nibble, input last, output ready);

endinterface

// File: rtl/kp_nibble_shifter.sv
// 2*SIZE load / shift-right-by-4 register with a running XOR of every
// nibble shifted out. When append is set on a shift, the updated XOR is
// placed in the low nibble, so the checksum comes out as the next nibble.
module kp_nibble_shifter
  import ecc_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                load,
  input  logic [FRAME_W-1:0]  load_data,
  input  logic                shift,
  input  logic                append,
  output logic [NIBBLE_W-1:0] nibble
);

  logic [FRAME_W-1:0]  data_q;
  logic [NIBBLE_W-1:0] acc_q;
  logic [NIBBLE_W-1:0] acc_n;

  assign acc_n  = acc_q ^ data_q[NIBBLE_W-1:0];
  assign nibble = data_q[NIBBLE_W-1:0];

  // Load a fresh {y,x} word or shift one nibble out, tracking the XOR.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_q <= '0;
      acc_q  <= '0;
    end else if (load) begin
      data_q <= load_data;
      acc_q  <= '0;
    end else if (shift) begin
      acc_q  <= acc_n;
      data_q <= (data_q >> NIBBLE_W) |
                (append ? {{(FRAME_W-NIBBLE_W){1'b0}}, acc_n} : '0);
    end
  end

endmodule

// File: rtl/kp_out_serializer.sv
// Streams the affine kP result (x then y, LSB nibble first) over the 4-bit
// kP pin with valid/ready, holding one pending result behind the active one.
// Optional: define ECC_OUT_CHECKSUM_EN to append an XOR checksum nibble.
module kp_out_serializer
  import ecc_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_done,
  input  logic [SIZE-1:0]            i_x,
  input  logic [SIZE-1:0]            i_y,
  kp_out_serializer_if.master        out_if,
  output logic                       o_frame_done,
  output logic                       o_busy,
  output logic                       o_overflow
);

  ser_state_t         state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [FRAME_W-1:0] pend_q;
  logic               pend_full_q, pend_full_n, pend_load;
  logic               valid_q, last_q, frame_done_q, busy_q, overflow_q;
  logic               overflow_n;
  logic               sh_load, sh_shift, sh_append;
  logic [FRAME_W-1:0] load_data;
  logic               xfer;

  assign xfer = valid_q & out_if.ready;

  kp_nibble_shifter u_shifter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .load      (sh_load),
    .load_data (load_data),
    .shift     (sh_shift),
    .append    (sh_append),
    .nibble    (out_if.nibble)
  );

  // Next state, shifter control and pending-slot decisions.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_append   = 1'b0;
    load_data   = {i_y, i_x};
    pend_full_n = pend_full_q;
    pend_load   = 1'b0;
    overflow_n  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_done) begin
          sh_load = 1'b1;
          cnt_n   = '0;
          state_n = ST_SEND_X;
        end
      end
      ST_SEND_X: begin
        if (xfer) begin
          sh_shift = 1'b1;
          cnt_n    = cnt_q + CNT_W'(1);
          if (cnt_q == X_LAST_CNT) state_n = ST_SEND_Y;
        end
      end
      ST_SEND_Y: begin
        if (xfer) begin
          sh_shift = 1'b1;
          cnt_n    = cnt_q + CNT_W'(1);
          if (cnt_q == Y_LAST_CNT) begin
`ifdef ECC_OUT_CHECKSUM_EN
            sh_append = 1'b1;
            state_n   = ST_CKSUM;
`else
            state_n   = ST_DONE;
`endif
          end
        end
      end
`ifdef ECC_OUT_CHECKSUM_EN
      ST_CKSUM: begin
        if (xfer) begin
          sh_shift = 1'b1;
          state_n  = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (pend_full_q) begin
          sh_load     = 1'b1;
          load_data   = pend_q;
          pend_full_n = 1'b0;
          cnt_n       = '0;
          state_n     = ST_SEND_X;
        end else if (i_done) begin
          sh_load = 1'b1;
          cnt_n   = '0;
          state_n = ST_SEND_X;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (i_done && (state_q != ST_IDLE) && !((state_q == ST_DONE) && !pend_full_q)) begin
      if (pend_full_q) begin
        overflow_n = 1'b1;
      end else begin
        pend_load   = 1'b1;
        pend_full_n = 1'b1;
      end
    end
  end

  // State, nibble counter and pending slot registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      pend_full_q <= pend_full_n;
      if (pend_load) pend_q <= {i_y, i_x};
    end
  end

  // Output flags registered from next-state values so none depend on i_ready.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      valid_q      <= state_n inside {ST_SEND_X, ST_SEND_Y, ST_CKSUM};
`ifdef ECC_OUT_CHECKSUM_EN
      last_q       <= (state_n == ST_CKSUM);
`else
      last_q       <= (state_n == ST_SEND_Y) && (cnt_n == Y_LAST_CNT);
`endif
      frame_done_q <= (state_n == ST_DONE);
      busy_q       <= (state_n != ST_IDLE) || pend_full_n;
      overflow_q   <= overflow_n;
    end
  end

  assign out_if.valid = valid_q;
  assign out_if.last  = last_q;
  assign o_frame_done = frame_done_q;
  assign o_busy       = busy_q;
  assign o_overflow   = overflow_q;

endmodule
